// File: rtl/lfsr_pkg.sv
// Shared constants and the single-shift helper for the parametrised Fibonacci LFSR.
package lfsr_pkg;

    localparam logic [3:0]  LFSR_TAPS_4  = 4'hC;
    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [25:0] LFSR_TAPS_26 = 26'h2000023;

    // Works on a 64-bit container; the caller zero-extends the state and truncates the result,
    // and the tap mask is zero above the real width, so the upper bits never reach the feedback.
    function automatic logic [63:0] lfsr_shift1(input logic [63:0] state, input logic [63:0] taps);
        logic fb;
        fb = ^(state & taps);
        return {state[62:0], fb};
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational unroll of STEP single-bit LFSR shifts; reports the bits shifted out, first one in the MSB.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 26,
    parameter int               STEP  = 1,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_26
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_state,
    output logic [STEP-1:0]  shifted
);

    logic [WIDTH-1:0] s;
    logic [63:0]      w;

    always_comb begin
        s       = state;
        w       = '0;
        shifted = '0;
        for (int i = 0; i < STEP; i++) begin
            shifted[STEP-1-i] = s[WIDTH-1];
            w              = '0;
            w[WIDTH-1:0]   = s;
            w              = lfsr_shift1(w, 64'(TAPS));
            s              = w[WIDTH-1:0];
        end
        next_state = s;
    end

endmodule

// File: rtl/lfsr_param.sv
// Parametrised Fibonacci LFSR with load, advance enable and all-zero lock-up recovery.
// Optional period tracking (seq_cnt, period_done) is built when LFSR_PERIOD_EN is defined.
module lfsr_param
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 26,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_26,
    parameter logic [WIDTH-1:0] SEED  = 1,
    parameter int               STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [STEP-1:0]  out_bits,
    output logic             lockup
`ifdef LFSR_PERIOD_EN
    ,
    output logic [WIDTH-1:0] seq_cnt,
    output logic             period_done
`endif
);

    generate
        if (STEP < 1 || STEP > WIDTH) begin : g_bad_step
            $error("lfsr_param: STEP must be in 1..WIDTH");
        end
        if (SEED == '0) begin : g_bad_seed
            $error("lfsr_param: SEED must be nonzero");
        end
        if (TAPS[WIDTH-1] == 1'b0) begin : g_bad_taps
            $error("lfsr_param: TAPS must include the top state bit");
        end
    endgenerate

    logic [WIDTH-1:0] step_next;
    logic [STEP-1:0]  step_bits;
    logic             load_zero;
    logic [WIDTH-1:0] load_val;

    lfsr_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .TAPS  (TAPS)
    ) u_step (
        .state      (q),
        .next_state (step_next),
        .shifted    (step_bits)
    );

    // An all-zero load would freeze the register, so it is replaced by SEED.
    assign load_zero = (din == '0);
    assign load_val  = load_zero ? SEED : din;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q        <= SEED;
            out_bits <= '0;
            lockup   <= 1'b0;
        end else if (load) begin
            q        <= load_val;
            lockup   <= load_zero;
        end else if (en) begin
            q        <= step_next;
            out_bits <= step_bits;
            lockup   <= 1'b0;
        end else begin
            lockup   <= 1'b0;
        end
    end

`ifdef LFSR_PERIOD_EN
    logic [WIDTH-1:0] ref_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_state   <= SEED;
            seq_cnt     <= '0;
            period_done <= 1'b0;
        end else if (load) begin
            ref_state   <= load_val;
            seq_cnt     <= '0;
            period_done <= 1'b0;
        end else if (en) begin
            seq_cnt     <= seq_cnt + WIDTH'(STEP);
            period_done <= (step_next == ref_state);
        end else begin
            period_done <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_param.sv
// Directed bench for lfsr_param: a STEP=1 and a STEP=2 instance (WIDTH=4, TAPS=4'hC, SEED=1)
// share one stimulus stream; period outputs are checked when LFSR_PERIOD_EN is defined.
module tb_lfsr_param;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       load;
    logic [3:0] din;

    logic [3:0] q1, q2;
    logic [0:0] out_bits1;
    logic [1:0] out_bits2;
    logic       lockup1, lockup2;
`ifdef LFSR_PERIOD_EN
    logic [3:0] seq_cnt1, seq_cnt2;
    logic       period_done1, period_done2;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Hand-derived state sequences for x^4+x^3+1 from seed 1.
    logic [3:0] seq1 [16] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                              4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    logic [3:0] seq2 [16] = '{4'h1, 4'h4, 4'h3, 4'hD, 4'h5, 4'h7, 4'hE, 4'h8,
                              4'h2, 4'h9, 4'h6, 4'hA, 4'hB, 4'hF, 4'hC, 4'h1};

    lfsr_param #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .STEP(1)) u_s1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .load        (load),
        .din         (din),
        .q           (q1),
        .out_bits    (out_bits1),
        .lockup      (lockup1)
`ifdef LFSR_PERIOD_EN
        ,
        .seq_cnt     (seq_cnt1),
        .period_done (period_done1)
`endif
    );

    lfsr_param #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .STEP(2)) u_s2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .load        (load),
        .din         (din),
        .q           (q2),
        .out_bits    (out_bits2),
        .lockup      (lockup2)
`ifdef LFSR_PERIOD_EN
        ,
        .seq_cnt     (seq_cnt2),
        .period_done (period_done2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        load  = 1'b1;
        din   = 4'h5;
        tick();
        tick();
        chk("rst_q1", q1, 4'h1);
        chk("rst_out1", out_bits1, 1'b0);
        chk("rst_lock1", lockup1, 1'b0);
        chk("rst_q2", q2, 4'h1);
        chk("rst_out2", out_bits2, 2'b00);
`ifdef LFSR_PERIOD_EN
        chk("rst_cnt1", seq_cnt1, 4'h0);
        chk("rst_pd1", period_done1, 1'b0);
`endif

        // Free-running advance on both instances: full period of 15.
        rst_n = 1'b1;
        load  = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk($sformatf("run_q1[%0d]", k), q1, seq1[k]);
            chk($sformatf("run_out1[%0d]", k), out_bits1, seq1[k-1][3]);
            chk($sformatf("run_q2[%0d]", k), q2, seq2[k]);
            chk($sformatf("run_out2[%0d]", k), out_bits2, seq2[k-1][3:2]);
`ifdef LFSR_PERIOD_EN
            chk($sformatf("run_cnt1[%0d]", k), seq_cnt1, 4'(k));
            chk($sformatf("run_pd1[%0d]", k), period_done1, (k == 15));
            chk($sformatf("run_cnt2[%0d]", k), seq_cnt2, 4'(2 * k));
            chk($sformatf("run_pd2[%0d]", k), period_done2, (k == 15));
`endif
            if (k == 2) chk("step2_4to3_bits", out_bits2, 2'b01);
            if (k == 3) chk("step1_4to9_bit", out_bits1, 1'b0);
            if (k == 4) chk("step1_9to3_bit", out_bits1, 1'b1);
            if (k == 7) chk("step1_DtoA_bit", out_bits1, 1'b1);
        end

        // Load beats enable; out_bits keeps the bit from the last advance (8->1 shifted out 1).
        load = 1'b1;
        din  = 4'h9;
        tick();
        chk("load_q1", q1, 4'h9);
        chk("load_out1_hold", out_bits1, 1'b1);
        chk("load_lock1", lockup1, 1'b0);
`ifdef LFSR_PERIOD_EN
        chk("load_cnt1", seq_cnt1, 4'h0);
`endif
        load = 1'b0;
        tick();
        chk("adv_after_load_q1", q1, 4'h3);
        en = 1'b0;
        tick();
        chk("hold_q1", q1, 4'h3);
        chk("hold_out1", out_bits1, 1'b1);
`ifdef LFSR_PERIOD_EN
        chk("hold_cnt1", seq_cnt1, 4'h1);
        chk("hold_pd1", period_done1, 1'b0);
`endif

        // Continue from 3 until the state returns to the loaded reference 9.
        en = 1'b1;
        for (int k = 2; k <= 15; k++) begin
            tick();
            chk($sformatf("ref_q1[%0d]", k), q1, seq1[(3 + k) % 15]);
`ifdef LFSR_PERIOD_EN
            chk($sformatf("ref_cnt1[%0d]", k), seq_cnt1, 4'(k));
            chk($sformatf("ref_pd1[%0d]", k), period_done1, (k == 15));
`endif
        end
        tick();
        chk("past_ref_q1", q1, 4'h3);
`ifdef LFSR_PERIOD_EN
        chk("past_ref_pd1", period_done1, 1'b0);
`endif

        // All-zero load is replaced by SEED with a one-cycle lockup pulse.
        en   = 1'b0;
        load = 1'b1;
        din  = 4'h0;
        tick();
        chk("zero_q1", q1, 4'h1);
        chk("zero_lock1", lockup1, 1'b1);
`ifdef LFSR_PERIOD_EN
        chk("zero_cnt1", seq_cnt1, 4'h0);
`endif
        load = 1'b0;
        en   = 1'b1;
        tick();
        chk("zero_adv_q1", q1, 4'h2);
        chk("zero_lock1_drop", lockup1, 1'b0);
        en = 1'b0;
        load = 1'b1;
        tick();
        chk("zero_again_lock1", lockup1, 1'b1);
        load = 1'b0;
        tick();
        chk("idle_lock1_drop", lockup1, 1'b0);
        chk("idle_q1", q1, 4'h1);

        // Run to the reference, then reset mid-stream with load and en both high.
        en = 1'b1;
        for (int k = 1; k <= 15; k++) tick();
        chk("pre_rst_q1", q1, 4'h1);
`ifdef LFSR_PERIOD_EN
        chk("pre_rst_pd1", period_done1, 1'b1);
`endif
        rst_n = 1'b0;
        load  = 1'b1;
        din   = 4'h7;
        tick();
        chk("mid_rst_q1", q1, 4'h1);
        chk("mid_rst_out1", out_bits1, 1'b0);
        chk("mid_rst_lock1", lockup1, 1'b0);
        chk("mid_rst_q2", q2, 4'h1);
        chk("mid_rst_out2", out_bits2, 2'b00);
`ifdef LFSR_PERIOD_EN
        chk("mid_rst_cnt1", seq_cnt1, 4'h0);
        chk("mid_rst_pd1", period_done1, 1'b0);
        chk("mid_rst_cnt2", seq_cnt2, 4'h0);
`endif
        rst_n = 1'b1;
        load  = 1'b0;
        tick();
        chk("post_rst_q1", q1, 4'h2);
        chk("post_rst_q2", q2, 4'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
